// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction memory of the pipelined core.
// It takes a byte stream over a valid/ready handshake. The stream starts with a
// 2-byte big-endian word count N, followed by 4*N bytes. Each group of four
// bytes is packed into a big-endian 32-bit word and written to consecutive word
// addresses starting at 0. The core is held in reset until the last write has
// landed in memory.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset of all loader state
//   in_valid     stream byte valid
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (registered)
//   mem_we       one-cycle instruction-memory write strobe
//   mem_addr     word address of the write (byte address = mem_addr*4)
//   mem_wdata    instruction word to write
//   cpu_reset    active-high reset to the core; low only once loading is done
//   done         program loaded and core released
//   err          header word count larger than the memory
//   words_loaded number of words written so far
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    // 17 bits so that DEPTH itself is representable even for ADDR_W = 16.
    localparam logic [16:0] DEPTH_W = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        DRAIN,
        DONE_S,
        ERR_S
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [7:0]          hdr_hi_reg;
    logic [15:0]         word_count_reg;
    logic [1:0]          byte_cnt_reg;
    logic [23:0]         shift_reg;
    logic [15:0]         words_loaded_reg;

    logic                in_ready_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [31:0]         mem_wdata_reg;
    logic                cpu_reset_reg;
    logic                done_reg;
    logic                err_reg;

    logic                xfer;
    logic [15:0]         hdr_n;
    logic                last_byte;
    logic                last_word;

    assign xfer      = in_valid && in_ready_reg;
    assign hdr_n     = {hdr_hi_reg, in_data};
    assign last_byte = (byte_cnt_reg == 2'd3);
    assign last_word = ((words_loaded_reg + 16'd1) == word_count_reg);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HDR_HI: begin
                if (xfer) state_next = HDR_LO;
            end
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_n == 16'd0)
                        state_next = DRAIN;
                    else if ({1'b0, hdr_n} > DEPTH_W)
                        state_next = ERR_S;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && last_byte && last_word) state_next = DRAIN;
            end
            // DRAIN spends exactly one cycle so the last write lands
            // before the core leaves reset.
            DRAIN:   state_next = DONE_S;
            DONE_S:  state_next = DONE_S;
            ERR_S:   state_next = ERR_S;
            default: state_next = HDR_HI;
        endcase
    end

    // State register plus status outputs decoded from the next state, so
    // every output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= HDR_HI;
            in_ready_reg  <= 1'b1;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == HDR_HI) || (state_next == HDR_LO) ||
                             (state_next == DATA);
            cpu_reset_reg <= (state_next != DONE_S);
            done_reg      <= (state_next == DONE_S);
            err_reg       <= (state_next == ERR_S);
        end
    end

    // Header capture, word assembly and memory write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_hi_reg       <= 8'd0;
            word_count_reg   <= 16'd0;
            byte_cnt_reg     <= 2'd0;
            shift_reg        <= 24'd0;
            words_loaded_reg <= 16'd0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= 32'd0;
        end else begin
            mem_we_reg <= 1'b0;
            if (xfer) begin
                case (state_reg)
                    HDR_HI: hdr_hi_reg <= in_data;
                    HDR_LO: word_count_reg <= hdr_n;
                    DATA: begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            mem_we_reg       <= 1'b1;
                            mem_addr_reg     <= words_loaded_reg[ADDR_W-1:0];
                            mem_wdata_reg    <= {shift_reg, in_data};
                            words_loaded_reg <= words_loaded_reg + 16'd1;
                        end else begin
                            shift_reg <= {shift_reg[15:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign words_loaded = words_loaded_reg;

endmodule
